// File: rtl/strhw_ctrl.sv
// Streebog message sequencer: streams 512-bit blocks into the stage core, keeps h/N/Sigma
// between calls, adds the zero-length finalisation call and presents the digest.
// Optional stage-call watchdog: define STRHW_CTRL_WDOG_EN (limit set by WDOG_CYCLES).
module strhw_ctrl #(
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         mode256_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic [6:0]   blk_size_i,
  input  logic         blk_last_i,
  output logic         stg_trg_o,
  output logic [511:0] stg_block_o,
  output logic [6:0]   stg_block_size_o,
  output logic [511:0] stg_h_o,
  output logic [511:0] stg_n_o,
  output logic [511:0] stg_sigma_o,
  input  logic [511:0] stg_h_new_i,
  input  logic [511:0] stg_n_new_i,
  input  logic [511:0] stg_sigma_new_i,
  input  logic [1:0]   stg_state_i,
  output logic [511:0] hash_o,
  output logic         hash_valid_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    STG_CLEAR = 2'd0,
    STG_BUSY  = 2'd1,
    STG_DONE  = 2'd2
  } stg_state_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BLK  = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_PAD       = 3'd5,
    S_FINISH    = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  localparam logic [511:0] IV256    = {64{8'h01}};
  localparam logic [6:0]   FULL_BLK = 7'd64;

  state_e       state_q, state_d;
  logic [511:0] h_q, h_d;
  logic [511:0] n_q, n_d;
  logic [511:0] sigma_q, sigma_d;
  logic [511:0] blk_q, blk_d;
  logic [6:0]   size_q, size_d;
  logic         last_q, last_d;
  logic         pad_q, pad_d;
  logic         mode256_q, mode256_d;
  logic [511:0] hash_q, hash_d;
  logic         hash_valid_q, hash_valid_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;
  logic         wdog_hit;
  logic         blk_bad;

  wdog_range_a: assert property (@(posedge clk_i) (WDOG_CYCLES >= 1) && (WDOG_CYCLES <= 65535));

`ifdef STRHW_CTRL_WDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

  logic [15:0] wdog_q, wdog_d;
  logic        in_wait;

  assign in_wait = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_LAUNCH) begin
      wdog_d = '0;
    end else if (in_wait) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // Fires on the edge where the count of waiting cycles reaches the limit.
  assign wdog_hit = in_wait && (wdog_d >= WDOG_LIMIT);
`else
  assign wdog_hit = 1'b0;
`endif

  assign blk_bad = (blk_size_i > FULL_BLK) || ((blk_size_i != FULL_BLK) && !blk_last_i);

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the values from before this edge regardless of statement order.
    if (rst_i) begin
      state_q      <= S_IDLE;
      // NOTE: the 512-bit registers are reset too; they drive outputs that must read 0 after reset.
      h_q          <= '0;
      n_q          <= '0;
      sigma_q      <= '0;
      blk_q        <= '0;
      size_q       <= '0;
      last_q       <= 1'b0;
      pad_q        <= 1'b0;
      mode256_q    <= 1'b0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      n_q          <= n_d;
      sigma_q      <= sigma_d;
      blk_q        <= blk_d;
      size_q       <= size_d;
      last_q       <= last_d;
      pad_q        <= pad_d;
      mode256_q    <= mode256_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves one unassigned (no latch).
    state_d      = state_q;
    h_d          = h_q;
    n_d          = n_q;
    sigma_d      = sigma_q;
    blk_d        = blk_q;
    size_d       = size_q;
    last_d       = last_q;
    pad_d        = pad_q;
    mode256_d    = mode256_q;
    hash_d       = hash_q;
    hash_valid_d = hash_valid_q;
    busy_d       = busy_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          h_d          = mode256_i ? IV256 : '0;
          n_d          = '0;
          sigma_d      = '0;
          mode256_d    = mode256_i;
          last_d       = 1'b0;
          pad_d        = 1'b0;
          hash_valid_d = 1'b0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_WAIT_BLK;
        end
      end

      S_WAIT_BLK: begin
        if (blk_valid_i) begin
          if (blk_bad) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            blk_d   = blk_data_i;
            size_d  = blk_size_i;
            last_d  = blk_last_i;
            state_d = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: state_d = S_WAIT_BUSY;

      // A DONE left over from the previous call must not count; wait for BUSY first.
      S_WAIT_BUSY: begin
        if (wdog_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (stg_state_i == STG_BUSY) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (stg_state_i == STG_DONE) begin
          h_d     = stg_h_new_i;
          n_d     = stg_n_new_i;
          sigma_d = stg_sigma_new_i;
          if (pad_q || (last_q && (size_q != FULL_BLK))) begin
            state_d = S_FINISH;
          end else if (last_q) begin
            state_d = S_PAD;
          end else begin
            state_d = S_WAIT_BLK;
          end
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      // A message ending on a full block still needs the empty finalisation call.
      S_PAD: begin
        blk_d   = '0;
        size_d  = '0;
        last_d  = 1'b0;
        pad_d   = 1'b1;
        state_d = S_LAUNCH;
      end

      S_FINISH: begin
        hash_d       = mode256_q ? {256'd0, h_q[511:256]} : h_q;
        hash_valid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    blk_ready_o = (state_q == S_WAIT_BLK);
    stg_trg_o   = (state_q == S_LAUNCH);
  end

  assign stg_block_o      = blk_q;
  assign stg_block_size_o = size_q;
  assign stg_h_o          = h_q;
  assign stg_n_o          = n_q;
  assign stg_sigma_o      = sigma_q;
  assign hash_o           = hash_q;
  assign hash_valid_o     = hash_valid_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_strhw_ctrl.sv
// Directed bench for strhw_ctrl with a toy stage core:
// N' = N + 8*size, Sigma' = Sigma + block, h' = (h ^ block) + N' + Sigma'.
module tb_strhw_ctrl;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [511:0] IV256 = {64{8'h01}};
  localparam logic [511:0] M1 = 512'h323130393837363534333231303938373635343332313039383736353433323130393837363534333231303938373635343332313039383736353433323130;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         mode256_i = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [511:0] blk_data_i = '0;
  logic [6:0]   blk_size_i = '0;
  logic         blk_last_i = 1'b0;
  logic         stg_trg_o;
  logic [511:0] stg_block_o;
  logic [6:0]   stg_block_size_o;
  logic [511:0] stg_h_o, stg_n_o, stg_sigma_o;
  logic [511:0] stg_h_new_i = '0, stg_n_new_i = '0, stg_sigma_new_i = '0;
  logic [1:0]   stg_state_i = ST_CLEAR;
  logic [511:0] hash_o;
  logic         hash_valid_o, busy_o, err_o;

  int vec_cnt = 0;
  int miss_cnt = 0;

  // Stage model state and monitors.
  logic         m_pend = 1'b0;
  logic         m_hang = 1'b0;
  logic [1:0]   m_cnt = '0;
  logic [511:0] cap_h = '0, cap_n = '0, cap_s = '0, cap_blk = '0;
  logic [6:0]   cap_size = '0;
  logic         trg_prev = 1'b0, hv_prev = 1'b0;
  int call_cnt = 0, trg_wide = 0, hv_rises = 0, stab_err = 0;

  always #5 clk_i = ~clk_i;

  strhw_ctrl #(.WDOG_CYCLES(20)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode256_i(mode256_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .blk_size_i(blk_size_i), .blk_last_i(blk_last_i),
    .stg_trg_o(stg_trg_o), .stg_block_o(stg_block_o), .stg_block_size_o(stg_block_size_o),
    .stg_h_o(stg_h_o), .stg_n_o(stg_n_o), .stg_sigma_o(stg_sigma_o),
    .stg_h_new_i(stg_h_new_i), .stg_n_new_i(stg_n_new_i), .stg_sigma_new_i(stg_sigma_new_i),
    .stg_state_i(stg_state_i),
    .hash_o(hash_o), .hash_valid_o(hash_valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  // Stage model: BUSY one cycle after the trigger, DONE four cycles after it.
  // Between calls it keeps showing DONE, so a controller that skips the BUSY wait sees stale results.
  always @(posedge clk_i) begin
    trg_prev <= stg_trg_o;
    hv_prev  <= hash_valid_o;
    if (stg_trg_o && trg_prev) trg_wide <= trg_wide + 1;
    if (hash_valid_o && !hv_prev) hv_rises <= hv_rises + 1;
    if (rst_i) begin
      stg_state_i <= ST_CLEAR;
      m_pend      <= 1'b0;
      m_cnt       <= '0;
    end else begin
      if ((m_pend || stg_state_i == ST_BUSY) &&
          ({stg_h_o, stg_n_o, stg_sigma_o, stg_block_o, stg_block_size_o} !==
           {cap_h, cap_n, cap_s, cap_blk, cap_size}))
        stab_err <= stab_err + 1;
      if (stg_trg_o) begin
        m_pend   <= 1'b1;
        call_cnt <= call_cnt + 1;
        cap_h    <= stg_h_o;
        cap_n    <= stg_n_o;
        cap_s    <= stg_sigma_o;
        cap_blk  <= stg_block_o;
        cap_size <= stg_block_size_o;
      end
      if (m_pend) begin
        m_pend      <= 1'b0;
        stg_state_i <= ST_BUSY;
        m_cnt       <= 2'd2;
      end else if (stg_state_i == ST_BUSY && !m_hang) begin
        if (m_cnt == 2'd0) begin
          stg_state_i     <= ST_DONE;
          stg_n_new_i     <= cap_n + ({505'd0, cap_size} << 3);
          stg_sigma_new_i <= cap_s + cap_blk;
          stg_h_new_i     <= (cap_h ^ cap_blk) + cap_n + ({505'd0, cap_size} << 3) + cap_s + cap_blk;
        end else begin
          m_cnt <= m_cnt - 2'd1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic do_start(input logic m256);
    @(negedge clk_i);
    start_i   = 1'b1;
    mode256_i = m256;
    @(negedge clk_i);
    start_i   = 1'b0;
  endtask

  // Presents one block and returns at the negedge after the handshake edge.
  task automatic send_block(input logic [511:0] d, input logic [6:0] sz, input logic lst,
                            output bit hs, output logic rdy_after);
    hs = 1'b0;
    @(negedge clk_i);
    blk_valid_i = 1'b1;
    blk_data_i  = d;
    blk_size_i  = sz;
    blk_last_i  = lst;
    for (int i = 0; i < 100; i++) begin
      if (blk_ready_o) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
    rdy_after   = blk_ready_o;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (hash_valid_o || err_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if ({busy_o, err_o, hash_valid_o, blk_ready_o, stg_trg_o} !== 5'b0) begin
      miss_cnt++;
      $display("FAIL reset_flags: got busy/err/hv/rdy/trg=%b want 00000",
               {busy_o, err_o, hash_valid_o, blk_ready_o, stg_trg_o});
    end
    vec_cnt++;
    if ({hash_o, stg_h_o, stg_n_o, stg_sigma_o, stg_block_o, stg_block_size_o} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_data: hash=%h h=%h blk=%h want all zero", hash_o, stg_h_o, stg_block_o);
    end
  endtask

  task automatic test_m1_512();
    bit hs, ok;
    logic rdy;
    int base;
    logic [511:0] exp;
    exp  = (M1 << 1) + 512'd504;
    base = call_cnt;
    do_start(1'b0);
    vec_cnt++;
    if (busy_o !== 1'b1) begin miss_cnt++; $display("FAIL m1_512 busy_after_start: got %b want 1", busy_o); end
    send_block(M1, 7'd63, 1'b1, hs, rdy);
    vec_cnt++;
    if (hs !== 1'b1) begin miss_cnt++; $display("FAIL m1_512 handshake: got %b want 1", hs); end
    vec_cnt++;
    if (rdy !== 1'b0) begin miss_cnt++; $display("FAIL m1_512 ready_after_hs: got %b want 0", rdy); end
    wait_result(ok);
    repeat (3) @(negedge clk_i);
    vec_cnt++;
    if (hash_o !== exp) begin miss_cnt++; $display("FAIL m1_512 hash: got %h want %h", hash_o, exp); end
    vec_cnt++;
    if ({hash_valid_o, busy_o, err_o} !== 3'b100) begin
      miss_cnt++;
      $display("FAIL m1_512 flags: got hv/busy/err=%b want 100 (ok=%b)", {hash_valid_o, busy_o, err_o}, ok);
    end
    vec_cnt++;
    if (call_cnt - base !== 1) begin miss_cnt++; $display("FAIL m1_512 calls: got %0d want 1", call_cnt - base); end
  endtask

  task automatic test_m1_256();
    bit hs, ok;
    logic rdy;
    logic [511:0] full, exp;
    full = (IV256 ^ M1) + 512'd504 + M1;
    exp  = {256'd0, full[511:256]};
    do_start(1'b1);
    send_block(M1, 7'd63, 1'b1, hs, rdy);
    wait_result(ok);
    vec_cnt++;
    if (cap_h !== IV256) begin miss_cnt++; $display("FAIL m1_256 iv: got %h want %h", cap_h, IV256); end
    vec_cnt++;
    if (hash_o !== exp || !ok) begin miss_cnt++; $display("FAIL m1_256 hash: got %h want %h", hash_o, exp); end
  endtask

  task automatic test_empty();
    bit hs, ok;
    logic rdy;
    int base;
    base = call_cnt;
    do_start(1'b1);
    send_block('0, 7'd0, 1'b1, hs, rdy);
    wait_result(ok);
    repeat (5) @(negedge clk_i);
    vec_cnt++;
    if (call_cnt - base !== 1) begin miss_cnt++; $display("FAIL empty calls: got %0d want 1", call_cnt - base); end
    vec_cnt++;
    if (hash_o !== {256'd0, IV256[511:256]} || !ok) begin
      miss_cnt++;
      $display("FAIL empty hash: got %h want %h", hash_o, {256'd0, IV256[511:256]});
    end
  endtask

  // Blocks 1 and 2 (64 bytes each): h1 = 514, h2 = 1539, pad call h3 = 2566.
  task automatic test_full_final();
    bit hs1, hs2, ok;
    logic rdy;
    int base_c, base_w, base_h, base_s;
    base_c = call_cnt; base_w = trg_wide; base_h = hv_rises; base_s = stab_err;
    do_start(1'b0);
    send_block(512'd1, 7'd64, 1'b0, hs1, rdy);
    send_block(512'd2, 7'd64, 1'b1, hs2, rdy);
    wait_result(ok);
    repeat (3) @(negedge clk_i);
    vec_cnt++;
    if (call_cnt - base_c !== 3) begin miss_cnt++; $display("FAIL full calls: got %0d want 3", call_cnt - base_c); end
    vec_cnt++;
    if ({cap_blk, cap_size} !== '0) begin
      miss_cnt++;
      $display("FAIL full pad_call: got blk=%h size=%0d want 0/0", cap_blk, cap_size);
    end
    vec_cnt++;
    if (hash_o !== 512'd2566 || !(hs1 && hs2 && ok)) begin
      miss_cnt++;
      $display("FAIL full hash: got %0d want 2566", hash_o);
    end
    vec_cnt++;
    if (hv_rises - base_h !== 1) begin miss_cnt++; $display("FAIL full hv_rises: got %0d want 1", hv_rises - base_h); end
    vec_cnt++;
    if (trg_wide - base_w !== 0) begin miss_cnt++; $display("FAIL full trg_width: got %0d wide pulses want 0", trg_wide - base_w); end
    vec_cnt++;
    if (stab_err - base_s !== 0) begin miss_cnt++; $display("FAIL full stability: got %0d changes want 0", stab_err - base_s); end
  endtask

  task automatic test_size_err();
    bit hs;
    logic rdy;
    int base;
    base = call_cnt;
    do_start(1'b0);
    send_block(M1, 7'd65, 1'b1, hs, rdy);
    vec_cnt++;
    if ({err_o, busy_o} !== 2'b10) begin miss_cnt++; $display("FAIL err65 flags: got err/busy=%b want 10", {err_o, busy_o}); end
    do_start(1'b0);
    vec_cnt++;
    if ({err_o, busy_o} !== 2'b01) begin miss_cnt++; $display("FAIL err65 restart: got err/busy=%b want 01", {err_o, busy_o}); end
    send_block(M1, 7'd10, 1'b0, hs, rdy);
    repeat (6) @(negedge clk_i);
    vec_cnt++;
    if ({err_o, busy_o} !== 2'b10) begin miss_cnt++; $display("FAIL err10 flags: got err/busy=%b want 10", {err_o, busy_o}); end
    vec_cnt++;
    if (call_cnt - base !== 0) begin miss_cnt++; $display("FAIL size_err calls: got %0d want 0", call_cnt - base); end
    do_start(1'b0);
    vec_cnt++;
    if (err_o !== 1'b0) begin miss_cnt++; $display("FAIL err10 clear: got %b want 0", err_o); end
  endtask

  task automatic test_reset_restart();
    bit hs, ok, seen;
    logic rdy;
    int base;
    do_reset();
    do_start(1'b1);
    send_block(M1, 7'd63, 1'b1, hs, rdy);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (stg_state_i == ST_BUSY) begin seen = 1'b1; break; end
    end
    do_reset();
    vec_cnt++;
    if ({busy_o, err_o, hash_valid_o, blk_ready_o, stg_trg_o} !== 5'b0 || !seen) begin
      miss_cnt++;
      $display("FAIL midreset_flags: got busy/err/hv/rdy/trg=%b want 00000 (busy seen=%b)",
               {busy_o, err_o, hash_valid_o, blk_ready_o, stg_trg_o}, seen);
    end
    vec_cnt++;
    if ({stg_h_o, stg_block_o, hash_o} !== '0) begin
      miss_cnt++;
      $display("FAIL midreset_data: h=%h blk=%h want zero", stg_h_o, stg_block_o);
    end
    base = call_cnt;
    do_start(1'b0);
    send_block(M1, 7'd63, 1'b1, hs, rdy);
    start_i = 1'b1; mode256_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; mode256_i = 1'b0;
    wait_result(ok);
    vec_cnt++;
    if (hash_o !== (M1 << 1) + 512'd504 || !ok) begin
      miss_cnt++;
      $display("FAIL restart hash: got %h want %h", hash_o, (M1 << 1) + 512'd504);
    end
    vec_cnt++;
    if (call_cnt - base !== 1) begin miss_cnt++; $display("FAIL restart calls: got %0d want 1", call_cnt - base); end
  endtask

`ifdef STRHW_CTRL_WDOG_EN
  // err_o must rise on the 20th clock edge after the edge that samples stg_trg_o.
  task automatic test_wdog();
    bit hs;
    logic rdy;
    int k;
    do_reset();
    m_hang = 1'b1;
    do_start(1'b0);
    send_block(M1, 7'd63, 1'b1, hs, rdy);
    vec_cnt++;
    if (stg_trg_o !== 1'b1) begin miss_cnt++; $display("FAIL wdog launch: got trg=%b want 1", stg_trg_o); end
    @(posedge clk_i);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      k++;
      #1;
      if (err_o) break;
    end
    vec_cnt++;
    if (k !== 20) begin miss_cnt++; $display("FAIL wdog timing: got %0d edges want 20", k); end
    @(negedge clk_i);
    vec_cnt++;
    if ({err_o, busy_o, blk_ready_o, hash_valid_o} !== 4'b1000) begin
      miss_cnt++;
      $display("FAIL wdog idle: got err/busy/rdy/hv=%b want 1000", {err_o, busy_o, blk_ready_o, hash_valid_o});
    end
    do_start(1'b0);
    vec_cnt++;
    if ({err_o, busy_o} !== 2'b01) begin miss_cnt++; $display("FAIL wdog restart: got err/busy=%b want 01", {err_o, busy_o}); end
    m_hang = 1'b0;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_m1_512();
    test_m1_256();
    test_empty();
    test_full_final();
    test_size_err();
    test_reset_restart();
`ifdef STRHW_CTRL_WDOG_EN
    test_wdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
